// File: rtl/wisc_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline latch: widths, occupancy state
// encoding, and the NOP word used to show a bubble to decode.
package wisc_pipe_pkg;

    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned DEF_PC_W    = 16;
    localparam int unsigned WORD_W      = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // Occupancy of the latch: no entry, head only, head plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_e;

    // Number of 16-bit flop words needed to hold w bits.
    function automatic int unsigned num_words(input int unsigned w);
        return (w + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: enable-load storage register made of 16-bit flop words.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low clear (contents go to 0)
//   ld   - load d on the next edge, hold otherwise
//   d    - W-bit load data
//   q    - W-bit stored value
module pipe_slot
    import wisc_pipe_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int unsigned NW    = num_words(W);
    localparam int unsigned PAD_W = NW * WORD_W;

    logic [PAD_W-1:0] d_pad;
    logic [PAD_W-1:0] q_pad;

    assign d_pad = PAD_W'(d);

    // One 16-bit word per iteration; all words share the same load enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_pad <= '0;
        end else if (ld) begin
            for (int unsigned i = 0; i < NW; i++) begin
                q_pad[i*WORD_W +: WORD_W] <= d_pad[i*WORD_W +: WORD_W];
            end
        end
    end

    assign q = q_pad[W-1:0];

endmodule

// File: rtl/if_id_skid_latch.sv
// if_id_skid_latch: IF/ID stage register with a 2-entry skid buffer.
// Holds fetched instruction + PC+2 and presents them to decode in order;
// decode back-pressure is absorbed by the skid slot so in_ready is a flop.
// Optional feature macro: IFID_BUBBLE_NOP_EN -- when defined, an empty latch
// drives NOP (16'h0800) on out_instr and 0 on out_pc_inc.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   in_valid/in_ready        - fetch-side handshake
//   in_instr/in_pc_inc       - fetched instruction and its PC+2
//   flush                    - squash all held entries and same-cycle input
//   out_valid/out_ready      - decode-side handshake
//   out_instr/out_pc_inc     - head entry
//   full                     - both slots occupied
module if_id_skid_latch
    import wisc_pipe_pkg::*;
#(
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned PC_W    = DEF_PC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc_inc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc_inc,
    output logic               full
);

    localparam int unsigned SLOT_W = INSTR_W + PC_W;

    ifid_state_e       state;
    ifid_state_e       state_nxt;
    logic              accept;
    logic              pop;
    logic              head_ld;
    logic              skid_ld;
    logic              head_from_skid;
    logic [SLOT_W-1:0] head_d;
    logic [SLOT_W-1:0] head_q;
    logic [SLOT_W-1:0] skid_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Next occupancy and slot load enables; flush overrides any accept/pop.
    always_comb begin
        state_nxt      = state;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        head_ld   = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_ld = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        skid_ld   = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_nxt      = ONE;
                        head_ld        = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State plus handshake/status flops, all derived from next occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            full      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            full      <= (state_nxt == FULL);
            in_ready  <= (state_nxt != FULL);
        end
    end

    assign head_d = head_from_skid ? skid_q : {in_instr, in_pc_inc};

    pipe_slot #(.W(SLOT_W)) u_head (
        .clk (clk),
        .rst (rst),
        .ld  (head_ld),
        .d   (head_d),
        .q   (head_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   ({in_instr, in_pc_inc}),
        .q   (skid_q)
    );

`ifdef IFID_BUBBLE_NOP_EN
    // Empty latch presents a NOP bubble instead of the stale head.
    assign out_instr  = out_valid ? head_q[SLOT_W-1 -: INSTR_W] : INSTR_W'(NOP_INSTR);
    assign out_pc_inc = out_valid ? head_q[PC_W-1:0] : '0;
`else
    assign out_instr  = head_q[SLOT_W-1 -: INSTR_W];
    assign out_pc_inc = head_q[PC_W-1:0];
`endif

endmodule

// File: tb/tb_if_id_skid_latch.sv
// Bench for if_id_skid_latch: directed stimulus with a FIFO scoreboard that
// records accepted entries and checks every decode-side pop in order.
module tb_if_id_skid_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc_inc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc_inc;
    logic        full;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];

    if_id_skid_latch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc_inc  (in_pc_inc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc_inc (out_pc_inc),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        in_valid  = v;
        in_instr  = ins;
        in_pc_inc = pc;
    endtask

    // Monitor: inputs are stable at the falling edge, so the upcoming
    // edge's accept/pop is known here.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got 0x%0h/0x%0h expected no output", out_instr, out_pc_inc);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    check("sb_instr", 32'(out_instr), 32'(e[31:16]));
                    check("sb_pc_inc", 32'(out_pc_inc), 32'(e[15:0]));
                end
            end
            if (in_valid && in_ready) sb.push_back({in_instr, in_pc_inc});
        end
    end

    logic [15:0] stream_instr [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0);

        // Reset
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'h0000);
        rst = 1'b1;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);

        // Stream with 1-cycle latency; second push is accept+pop in ONE
        out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h0002);
        tick();
        check("s_valid0", 32'(out_valid), 32'd1);
        check("s_instr0", 32'(out_instr), 32'h1234);
        drive(1'b1, 16'h5678, 16'h0004);
        tick();
        check("s_valid1", 32'(out_valid), 32'd1);
        check("s_instr1", 32'(out_instr), 32'h5678);
        check("s_pc1", 32'(out_pc_inc), 32'h0004);
        check("s_full1", 32'(full), 32'd0);
        drive(1'b0, 16'h0, 16'h0);
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
`ifdef IFID_BUBBLE_NOP_EN
        check("idle_instr_nop", 32'(out_instr), 32'h0800);
        check("idle_pc_zero", 32'(out_pc_inc), 32'h0000);
`else
        check("idle_instr_held", 32'(out_instr), 32'h5678);
        check("idle_pc_held", 32'(out_pc_inc), 32'h0004);
`endif

        // Sustained throughput
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream_instr[i], 16'(2 * i + 16'h0100));
            tick();
            check("thr_valid", 32'(out_valid), 32'd1);
            check("thr_instr", 32'(out_instr), 32'(stream_instr[i]));
        end
        drive(1'b0, 16'h0, 16'h0);
        tick();
        check("thr_drain", 32'(out_valid), 32'd0);

        // Back-pressure: A, B fill, C held off
        out_ready = 1'b0;
        drive(1'b1, 16'hA001, 16'h0010);
        tick();
        drive(1'b1, 16'hB002, 16'h0012);
        tick();
        check("bp_full", 32'(full), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'hC003, 16'h0014);
        tick();
        check("bp_hold_full", 32'(full), 32'd1);
        check("bp_hold_instr", 32'(out_instr), 32'hA001);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", 32'(out_instr), 32'hB002);
        check("bp_full_clr", 32'(full), 32'd0);
        check("bp_ready_set", 32'(in_ready), 32'd1);
        tick();
        check("bp_head_c", 32'(out_instr), 32'hC003);
        drive(1'b0, 16'h0, 16'h0);
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Flush in FULL with input present
        out_ready = 1'b0;
        drive(1'b1, 16'hD004, 16'h0020);
        tick();
        drive(1'b1, 16'hE005, 16'h0022);
        tick();
        drive(1'b1, 16'hF006, 16'h0024);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        check("fl_full_valid", 32'(out_valid), 32'd0);
        check("fl_full_full", 32'(full), 32'd0);
        check("fl_full_ready", 32'(in_ready), 32'd1);

        // Flush in ONE drops an otherwise-acceptable input
        drive(1'b1, 16'h7007, 16'h0030);
        tick();
        drive(1'b1, 16'h8008, 16'h0032);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        check("fl_one_valid", 32'(out_valid), 32'd0);
        tick();
        check("fl_one_stay", 32'(out_valid), 32'd0);

        // Normal push after flush
        out_ready = 1'b1;
        drive(1'b1, 16'h9009, 16'h0034);
        tick();
        check("post_fl_valid", 32'(out_valid), 32'd1);
        check("post_fl_instr", 32'(out_instr), 32'h9009);
        drive(1'b0, 16'h0, 16'h0);
        tick();
        check("post_fl_drain", 32'(out_valid), 32'd0);

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
